// File: rtl/display_output_pkg.sv
// Shared types and helpers for the display output path.
// NUM_DIGITS is limited to 8 because an_onehot_low returns 8 bits.
package display_output_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam int         MAX_DIGITS = 8;

  // Active-low one-hot anode word: only the anode of digit idx is driven low.
  // Callers size-cast the result down to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] an_onehot_low(input logic [2:0] idx);
    an_onehot_low = ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_counter.sv
// Free-running digit scan counter for multiplexed 7-segment displays.
// Each digit stays selected for REFRESH_DIV clocks, then the next digit is selected.
module seg_scan_counter #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 4,
  parameter int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             i_clock,
  input  logic             i_resetN,
  output logic [DIG_W-1:0] o_digitIdx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] r_refreshCnt;
  logic [DIG_W-1:0] r_digitIdx;

  // Count out the refresh period and step to the next digit on each wrap.
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_refreshCnt <= '0;
      r_digitIdx   <= '0;
    end else if (r_refreshCnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_refreshCnt <= '0;
      if (r_digitIdx == DIG_W'(NUM_DIGITS - 1)) begin
        r_digitIdx <= '0;
      end else begin
        r_digitIdx <= r_digitIdx + DIG_W'(1);
      end
    end else begin
      r_refreshCnt <= r_refreshCnt + CNT_W'(1);
    end
  end

  assign o_digitIdx = r_digitIdx;

endmodule

// File: rtl/display_output_arbiter.sv
// Selects one task channel by flag and drives the 7-seg anodes, segments and LEDs.
// A selection change forces a blanking interval so no mixed frame reaches the pins.
module display_output_arbiter
  import display_output_pkg::*;
#(
  parameter int NUM_TASKS    = 5,
  parameter int SEL_W        = 3,
  parameter int NUM_DIGITS   = 4,
  parameter int LED_W        = 16,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                              CLOCK,
  input  logic                              RESET_N,
  input  logic [SEL_W-1:0]                  flag,
  input  logic [NUM_TASKS*NUM_DIGITS*8-1:0] task_seg,
  input  logic [NUM_TASKS*LED_W-1:0]        task_led,
  input  logic [NUM_TASKS-1:0]              task_led_en,
  output logic [NUM_DIGITS-1:0]             AN,
  output logic [7:0]                        SEG,
  output logic [LED_W-1:0]                  led,
  output logic                              switching
);

  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);

  logic [SEL_W-1:0]      r_flagMeta;
  logic [SEL_W-1:0]      r_flagSync;
  state_t                r_state;
  state_t                w_stateNext;
  logic [BLANK_W-1:0]    r_blankCnt;
  logic [BLANK_W-1:0]    w_blankCntNext;
  logic [SEL_W-1:0]      r_target;
  logic [SEL_W-1:0]      w_targetNext;
  logic [SEL_W-1:0]      r_activeSel;
  logic [SEL_W-1:0]      w_activeSelNext;
  logic [DIG_W-1:0]      w_digitIdx;
  logic                  w_selHit;
  logic [7:0]            w_segPick;
  logic [LED_W-1:0]      w_ledPick;
  logic                  w_ledEnPick;
  logic [NUM_DIGITS-1:0] w_anNext;
  logic [7:0]            w_segNext;
  logic [LED_W-1:0]      w_ledNext;

  seg_scan_counter #(
    .REFRESH_DIV (REFRESH_DIV),
    .NUM_DIGITS  (NUM_DIGITS),
    .DIG_W       (DIG_W)
  ) u_scan (
    .i_clock    (CLOCK),
    .i_resetN   (RESET_N),
    .o_digitIdx (w_digitIdx)
  );

  // Two-flop synchroniser for the switch-driven flag input.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_flagMeta <= '0;
      r_flagSync <= '0;
    end else begin
      r_flagMeta <= flag;
      r_flagSync <= r_flagMeta;
    end
  end

  // FSM state, blank countdown, pending target and committed selection.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_BLANK;
      r_blankCnt  <= BLANK_LOAD;
      r_target    <= '0;
      r_activeSel <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_blankCnt  <= w_blankCntNext;
      r_target    <= w_targetNext;
      r_activeSel <= w_activeSelNext;
    end
  end

  // Next-state logic: any new request (re)starts a full blank before it is committed.
  always_comb begin
    w_stateNext     = r_state;
    w_blankCntNext  = r_blankCnt;
    w_targetNext    = r_target;
    w_activeSelNext = r_activeSel;
    case (r_state)
      ST_ACTIVE: begin
        if (r_flagSync != r_activeSel) begin
          w_stateNext    = ST_BLANK;
          w_targetNext   = r_flagSync;
          w_blankCntNext = BLANK_LOAD;
        end
      end
      ST_BLANK: begin
        if (r_flagSync != r_target) begin
          w_targetNext   = r_flagSync;
          w_blankCntNext = BLANK_LOAD;
        end else if (r_blankCnt == '0) begin
          w_stateNext     = ST_ACTIVE;
          w_activeSelNext = r_target;
        end else begin
          w_blankCntNext = r_blankCnt - BLANK_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_BLANK;
      end
    endcase
  end

  // Pick the selected task's current digit pattern and LED word; an out-of-range selection matches nothing.
  always_comb begin
    w_selHit    = 1'b0;
    w_segPick   = SEG_OFF;
    w_ledPick   = '0;
    w_ledEnPick = 1'b0;
    for (int t = 0; t < NUM_TASKS; t++) begin
      if (r_activeSel == SEL_W'(t)) begin
        w_selHit    = 1'b1;
        w_ledPick   = task_led[t*LED_W +: LED_W];
        w_ledEnPick = task_led_en[t];
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (w_digitIdx == DIG_W'(d)) begin
            w_segPick = task_seg[(t*NUM_DIGITS + d)*8 +: 8];
          end
        end
      end
    end
  end

  // Output values: dark in BLANK or with an invalid selection, otherwise the scanned digit.
  always_comb begin
    w_anNext  = '1;
    w_segNext = SEG_OFF;
    w_ledNext = '0;
    if (r_state == ST_ACTIVE && w_selHit) begin
      w_anNext  = NUM_DIGITS'(an_onehot_low(3'(w_digitIdx)));
      w_segNext = w_segPick;
      w_ledNext = w_ledEnPick ? w_ledPick : '0;
    end
  end

  // Register all pin outputs so the pins never see combinational glitches.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      AN        <= '1;
      SEG       <= SEG_OFF;
      led       <= '0;
      switching <= 1'b1;
    end else begin
      AN        <= w_anNext;
      SEG       <= w_segNext;
      led       <= w_ledNext;
      switching <= (r_state == ST_BLANK);
    end
  end

endmodule

// File: tb/tb_display_output_arbiter.sv
// Directed, table-driven bench for display_output_arbiter with a short refresh and blank.
module tb_display_output_arbiter;

  localparam int NUM_TASKS    = 5;
  localparam int SEL_W        = 3;
  localparam int NUM_DIGITS   = 4;
  localparam int LED_W        = 16;
  localparam int REFRESH_DIV  = 4;
  localparam int BLANK_CYCLES = 3;
  localparam int NUM_VECS     = 34;

  typedef struct {
    int          adv;
    logic [2:0]  flag;
    logic [4:0]  ledEn;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] led;
    logic        sw;
  } vec_t;

  logic                              CLOCK;
  logic                              RESET_N;
  logic [SEL_W-1:0]                  flag;
  logic [NUM_TASKS*NUM_DIGITS*8-1:0] taskSeg;
  logic [NUM_TASKS*LED_W-1:0]        taskLed;
  logic [NUM_TASKS-1:0]              taskLedEn;
  logic [NUM_DIGITS-1:0]             AN;
  logic [7:0]                        SEG;
  logic [LED_W-1:0]                  led;
  logic                              switching;

  int   total;
  int   bad;
  int   ghostCount;
  vec_t vecs [NUM_VECS];

  display_output_arbiter #(
    .NUM_TASKS    (NUM_TASKS),
    .SEL_W        (SEL_W),
    .NUM_DIGITS   (NUM_DIGITS),
    .LED_W        (LED_W),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .flag        (flag),
    .task_seg    (taskSeg),
    .task_led    (taskLed),
    .task_led_en (taskLedEn),
    .AN          (AN),
    .SEG         (SEG),
    .led         (led),
    .switching   (switching)
  );

  // 100 MHz-style clock, period 10.
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Task 2 is only ever requested and immediately superseded, so its pattern must never be lit.
  always @(negedge CLOCK) begin
    if (RESET_N && AN != 4'hF && SEG[7:4] == 4'h2) ghostCount++;
  end

  // Drive inputs at a falling edge, then let adv rising edges pass, ending on a falling edge.
  task automatic applyStimulus(input logic [2:0] f, input logic [4:0] en, input int adv);
    flag      = f;
    taskLedEn = en;
    repeat (adv) @(negedge CLOCK);
  endtask

  task automatic checkOne(input string name, input string field, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s %s got=%h want=%h", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expAn, input logic [7:0] expSeg,
                             input logic [15:0] expLed, input logic expSw);
    checkOne(name, "AN", 32'(AN), 32'(expAn));
    checkOne(name, "SEG", 32'(SEG), 32'(expSeg));
    checkOne(name, "led", 32'(led), 32'(expLed));
    checkOne(name, "switching", 32'(switching), 32'(expSw));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    ghostCount = 0;

    // adv, flag, ledEn, AN, SEG, led, switching  (cycle count after release in comments)
    vecs[0]  = '{0, 3'd0, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n0 reset values
    vecs[1]  = '{3, 3'd0, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n3 still blank
    vecs[2]  = '{1, 3'd0, 5'h1F, 4'hE, 8'h00, 16'h0001, 1'b0}; // n4 first lit digit
    vecs[3]  = '{1, 3'd0, 5'h1F, 4'hD, 8'h01, 16'h0001, 1'b0}; // n5
    vecs[4]  = '{4, 3'd0, 5'h1F, 4'hB, 8'h02, 16'h0001, 1'b0}; // n9
    vecs[5]  = '{4, 3'd0, 5'h1F, 4'h7, 8'h03, 16'h0001, 1'b0}; // n13
    vecs[6]  = '{4, 3'd0, 5'h1F, 4'hE, 8'h00, 16'h0001, 1'b0}; // n17 digit wraps
    vecs[7]  = '{1, 3'd3, 5'h1F, 4'hE, 8'h00, 16'h0001, 1'b0}; // n18 flag->3 in sync
    vecs[8]  = '{2, 3'd3, 5'h1F, 4'hE, 8'h00, 16'h0001, 1'b0}; // n20
    vecs[9]  = '{1, 3'd3, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n21 blank starts
    vecs[10] = '{2, 3'd3, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n23 last blank
    vecs[11] = '{1, 3'd3, 5'h1F, 4'hD, 8'h31, 16'h0008, 1'b0}; // n24 task 3, scan continuous
    vecs[12] = '{1, 3'd3, 5'h1F, 4'hB, 8'h32, 16'h0008, 1'b0}; // n25
    vecs[13] = '{4, 3'd3, 5'h1F, 4'h7, 8'h33, 16'h0008, 1'b0}; // n29
    vecs[14] = '{4, 3'd3, 5'h1F, 4'hE, 8'h30, 16'h0008, 1'b0}; // n33
    vecs[15] = '{1, 3'd2, 5'h1F, 4'hE, 8'h30, 16'h0008, 1'b0}; // n34 flag->2
    vecs[16] = '{2, 3'd2, 5'h1F, 4'hE, 8'h30, 16'h0008, 1'b0}; // n36
    vecs[17] = '{1, 3'd4, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n37 flag->4 during blank
    vecs[18] = '{2, 3'd4, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n39 restart
    vecs[19] = '{3, 3'd4, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n42 still blank
    vecs[20] = '{1, 3'd4, 5'h1F, 4'hB, 8'h42, 16'h0010, 1'b0}; // n43 task 4
    vecs[21] = '{2, 3'd4, 5'h1F, 4'h7, 8'h43, 16'h0010, 1'b0}; // n45
    vecs[22] = '{3, 3'd6, 5'h1F, 4'h7, 8'h43, 16'h0010, 1'b0}; // n48 flag->6 invalid
    vecs[23] = '{1, 3'd6, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n49
    vecs[24] = '{2, 3'd6, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n51
    vecs[25] = '{1, 3'd6, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b0}; // n52 invalid: dark, not switching
    vecs[26] = '{4, 3'd6, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b0}; // n56
    vecs[27] = '{3, 3'd1, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b0}; // n59 flag->1
    vecs[28] = '{1, 3'd1, 5'h1F, 4'hF, 8'hFF, 16'h0000, 1'b1}; // n60
    vecs[29] = '{3, 3'd1, 5'h1F, 4'h7, 8'h13, 16'h0002, 1'b0}; // n63 task 1
    vecs[30] = '{1, 3'd1, 5'h1D, 4'h7, 8'h13, 16'h0000, 1'b0}; // n64 led enable dropped
    vecs[31] = '{1, 3'd1, 5'h1D, 4'hE, 8'h10, 16'h0000, 1'b0}; // n65
    vecs[32] = '{1, 3'd1, 5'h1F, 4'hE, 8'h10, 16'h0002, 1'b0}; // n66 re-enabled
    vecs[33] = '{7, 3'd3, 5'h1F, 4'hB, 8'h32, 16'h0008, 1'b0}; // n73 task 3 before reset

    for (int t = 0; t < NUM_TASKS; t++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        taskSeg[(t*NUM_DIGITS + d)*8 +: 8] = 8'(16*t + d);
      end
      taskLed[t*LED_W +: LED_W] = 16'(1 << t);
    end
    flag      = 3'd0;
    taskLedEn = 5'h1F;
    RESET_N   = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;

    for (int i = 0; i < NUM_VECS; i++) begin
      applyStimulus(vecs[i].flag, vecs[i].ledEn, vecs[i].adv);
      checkOutput($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].led, vecs[i].sw);
    end

    // Mid-frame reset with task 3 lit: outputs must go dark without waiting for a clock.
    #2 RESET_N = 1'b0;
    #1 checkOutput("rstAsync", 4'hF, 8'hFF, 16'h0000, 1'b1);
    @(negedge CLOCK);
    checkOutput("rstHeld", 4'hF, 8'hFF, 16'h0000, 1'b1);
    @(negedge CLOCK);
    RESET_N = 1'b1;
    // Synchroniser restarts at 0, so flag 3 arrives mid-blank and restarts it.
    applyStimulus(3'd3, 5'h1F, 3);
    checkOutput("rstBlankA", 4'hF, 8'hFF, 16'h0000, 1'b1);
    applyStimulus(3'd3, 5'h1F, 3);
    checkOutput("rstBlankB", 4'hF, 8'hFF, 16'h0000, 1'b1);
    applyStimulus(3'd3, 5'h1F, 1);
    checkOutput("rstShow", 4'hD, 8'h31, 16'h0008, 1'b0);
    applyStimulus(3'd3, 5'h1F, 4);
    checkOutput("rstScan", 4'hB, 8'h32, 16'h0008, 1'b0);

    checkOne("ghost", "task2Cycles", 32'(ghostCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
